// File: rtl/msx_io_initiator_pkg.sv
// rtl/msx_io_initiator_pkg.sv - shared states and constants for the MSX I/O initiator
package msx_io_initiator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_DONE
  } io_state_e;

  localparam logic [7:0]  OPEN_BUS_DATA     = 8'hFF;
  localparam int unsigned DEFAULT_CLK_DIV   = 6;
  localparam int unsigned DEFAULT_TIMEOUT_T = 1024;

  // IORQ_n and RD_n/WR_n are held low for the whole T2..T3 span
  function automatic logic strobe_state(input io_state_e s);
    return (s == S_T2) || (s == S_TW) || (s == S_T3);
  endfunction

endpackage

// File: rtl/msx_tstate_tick.sv
// rtl/msx_tstate_tick.sv - T-state length counter, pulses last on the final clock of each T-state
module msx_tstate_tick #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic CLK,
  input  logic RESET,
  input  logic restart,
  output logic last
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] count;

  // Wrapping on zero lets back-to-back TW states run without an explicit restart
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= RELOAD;
    end else if (restart || (count == 8'd0)) begin
      count <= RELOAD;
    end else begin
      count <= count - 8'd1;
    end
  end

  assign last = (count == 8'd0);

endmodule

// File: rtl/msx_io_initiator.sv
// rtl/msx_io_initiator.sv - MSX bus I/O read/write cycle initiator (T1/T2/TW/T3 sequencer)
// Optional TW timeout abort is enabled by defining MSX_IO_INITIATOR_TIMEOUT_EN.
module msx_io_initiator
  import msx_io_initiator_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int unsigned TIMEOUT_T = DEFAULT_TIMEOUT_T
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_WR,
  input  logic [7:0]  REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        READY,
  output logic        DONE,
  output logic [7:0]  RDATA,
  output logic        ERR,
  output logic [15:0] BUS_ADDR,
  output logic        BUS_IORQ_n,
  output logic        BUS_RD_n,
  output logic        BUS_WR_n,
  output logic [7:0]  BUS_DOUT,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_BUSDIR_n,
  input  logic        BUS_WAIT_n,
  input  logic        BUS_INT_n,
  output logic        INT
);

  io_state_e   state_q, state_d;
  logic        tick_last;
  logic        accept;
  logic        wait_ok;
  logic        abort;
  logic        tw_expired;
  logic        wr_q;
  logic        err_q;
  logic [7:0]  rdata_q;
  logic [7:0]  dout_q;
  logic [15:0] addr_q;
  logic        iorq_n_q, rd_n_q, wr_n_q;
  logic [1:0]  wait_sync;
  logic [1:0]  int_sync;

  assign READY      = (state_q == S_IDLE);
  assign DONE       = (state_q == S_DONE);
  assign accept     = REQ && READY;
  assign RDATA      = rdata_q;
  assign ERR        = err_q;
  assign BUS_ADDR   = addr_q;
  assign BUS_DOUT   = dout_q;
  assign BUS_IORQ_n = iorq_n_q;
  assign BUS_RD_n   = rd_n_q;
  assign BUS_WR_n   = wr_n_q;
  assign wait_ok    = wait_sync[1];
  assign INT        = !int_sync[1];

  msx_tstate_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK     (CLK),
    .RESET   (RESET),
    .restart (state_d != state_q),
    .last    (tick_last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_sync <= 2'b11;
      int_sync  <= 2'b11;
    end else begin
      wait_sync <= {wait_sync[0], BUS_WAIT_n};
      int_sync  <= {int_sync[0], BUS_INT_n};
    end
  end

`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
  logic [15:0] tw_count;

  // tw_count holds the number of TW states already completed in this cycle
  assign tw_expired = (tw_count == 16'(TIMEOUT_T - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tw_count <= 16'd0;
    end else if (accept) begin
      tw_count <= 16'd0;
    end else if ((state_q == S_TW) && tick_last) begin
      tw_count <= tw_count + 16'd1;
    end
  end
`else
  logic unused_timeout;

  assign tw_expired     = 1'b0;
  assign unused_timeout = (TIMEOUT_T != 0);
`endif

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_T1;
      S_T1:   if (tick_last) state_d = S_T2;
      S_T2:   if (tick_last) state_d = S_TW;
      S_TW: begin
        if (tick_last) begin
          if (wait_ok) begin
            state_d = S_T3;
          end else if (tw_expired) begin
            state_d = S_T3;
            abort   = 1'b1;
          end
        end
      end
      S_T3:   if (tick_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      addr_q   <= 16'h0000;
      dout_q   <= 8'h00;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= OPEN_BUS_DATA;
      iorq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      // Strobes follow the next state so they change on the T2 entry and T3 exit edges
      iorq_n_q <= !strobe_state(state_d);
      rd_n_q   <= !(strobe_state(state_d) && !wr_q);
      wr_n_q   <= !(strobe_state(state_d) && wr_q);
      if (accept) begin
        addr_q <= {8'h00, REQ_ADDR};
        dout_q <= REQ_WR ? REQ_WDATA : 8'h00;
        wr_q   <= REQ_WR;
        err_q  <= 1'b0;
      end
      if (abort) begin
        err_q <= 1'b1;
      end
      if ((state_q == S_T3) && tick_last) begin
        rdata_q <= (!wr_q && !err_q && !BUS_BUSDIR_n) ? BUS_DIN : OPEN_BUS_DATA;
      end
    end
  end

endmodule

// File: tb/tb_msx_io_initiator.sv
// tb/tb_msx_io_initiator.sv - directed scoreboard bench for msx_io_initiator
module tb_msx_io_initiator;

  localparam int N   = 6;
  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ = 1'b0;
  logic        REQ_WR = 1'b0;
  logic [7:0]  REQ_ADDR = 8'h00;
  logic [7:0]  REQ_WDATA = 8'h00;
  logic        READY;
  logic        DONE;
  logic [7:0]  RDATA;
  logic        ERR;
  logic [15:0] BUS_ADDR;
  logic        BUS_IORQ_n;
  logic        BUS_RD_n;
  logic        BUS_WR_n;
  logic [7:0]  BUS_DOUT;
  logic [7:0]  BUS_DIN = 8'h00;
  logic        BUS_BUSDIR_n = 1'b1;
  logic        BUS_WAIT_n = 1'b1;
  logic        BUS_INT_n = 1'b1;
  logic        INT;

  always #5 CLK = ~CLK;

  msx_io_initiator #(
    .CLK_DIV   (N),
    .TIMEOUT_T (TMO)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQ          (REQ),
    .REQ_WR       (REQ_WR),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .READY        (READY),
    .DONE         (DONE),
    .RDATA        (RDATA),
    .ERR          (ERR),
    .BUS_ADDR     (BUS_ADDR),
    .BUS_IORQ_n   (BUS_IORQ_n),
    .BUS_RD_n     (BUS_RD_n),
    .BUS_WR_n     (BUS_WR_n),
    .BUS_DOUT     (BUS_DOUT),
    .BUS_DIN      (BUS_DIN),
    .BUS_BUSDIR_n (BUS_BUSDIR_n),
    .BUS_WAIT_n   (BUS_WAIT_n),
    .BUS_INT_n    (BUS_INT_n),
    .INT          (INT)
  );

  typedef struct {
    int         done_k;
    logic [7:0] rdata;
    logic       err;
    int         first_k;
    int         last_k;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Clocks are counted from the accept edge (clock 0); sampling is on the falling edge
  task automatic run_req(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic responder, input logic [7:0] din,
                         input int wait_from, input int wait_to, input int budget,
                         input int extra_tw, input logic exp_err);
    exp_t       e;
    exp_t       got;
    int         first_k = -1;
    int         last_k  = -1;
    int         done_k  = -1;
    logic       rd_seen = 1'b0;
    logic       wr_seen = 1'b0;
    logic [7:0] rdata_cap = 8'h00;
    logic       err_cap = 1'b0;
    @(negedge CLK);
    chk({tag, "_ready_before"}, {31'd0, READY}, 32'd1);
    REQ       = 1'b1;
    REQ_WR    = wr;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    e.done_k  = 4 * N + 1 + extra_tw * N;
    e.err     = exp_err;
    e.rdata   = (wr || !responder || exp_err) ? 8'hFF : din;
    e.first_k = N + 1;
    e.last_k  = e.done_k - 1;
    sb.push_back(e);
    @(posedge CLK);
    for (int k = 1; k <= budget && done_k < 0; k++) begin
      @(negedge CLK);
      REQ = 1'b0;
      if (k == 1) begin
        chk({tag, "_ready_busy"}, {31'd0, READY}, 32'd0);
        chk({tag, "_bus_addr"}, {16'd0, BUS_ADDR}, {24'd0, addr});
        chk({tag, "_bus_dout"}, {24'd0, BUS_DOUT}, {24'd0, (wr ? wdata : 8'h00)});
      end
      if (!BUS_IORQ_n) begin
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (!BUS_RD_n) rd_seen = 1'b1;
      if (!BUS_WR_n) wr_seen = 1'b1;
      if (DONE) begin
        done_k    = k;
        rdata_cap = RDATA;
        err_cap   = ERR;
      end
      BUS_WAIT_n   = !(k >= wait_from && k <= wait_to);
      BUS_BUSDIR_n = !(responder && !BUS_RD_n);
      BUS_DIN      = (responder && !BUS_RD_n) ? din : 8'h00;
    end
    BUS_WAIT_n   = 1'b1;
    BUS_BUSDIR_n = 1'b1;
    BUS_DIN      = 8'h00;
    got = sb.pop_front();
    if (done_k < 0) begin
      $error("FAIL %s_done_timeout observed=no DONE in %0d clocks expected=DONE at clock %0d",
             tag, budget, got.done_k);
      n_checks++;
    end else begin
      chk({tag, "_done_clock"}, done_k, got.done_k);
      chk({tag, "_rdata"}, {24'd0, rdata_cap}, {24'd0, got.rdata});
      chk({tag, "_err"}, {31'd0, err_cap}, {31'd0, got.err});
      chk({tag, "_strobe_first"}, first_k, got.first_k);
      chk({tag, "_strobe_last"}, last_k, got.last_k);
      chk({tag, "_rd_strobe"}, {31'd0, rd_seen}, {31'd0, !wr});
      chk({tag, "_wr_strobe"}, {31'd0, wr_seen}, {31'd0, wr});
      @(negedge CLK);
      chk({tag, "_ready_after"}, {31'd0, READY}, 32'd1);
      chk({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
    end
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", {31'd0, READY}, 32'd1);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_rdata", {24'd0, RDATA}, 32'hFF);
    chk("rst_addr", {16'd0, BUS_ADDR}, 32'd0);
    chk("rst_dout", {24'd0, BUS_DOUT}, 32'd0);
    chk("rst_strobes", {29'd0, BUS_IORQ_n, BUS_RD_n, BUS_WR_n}, 32'd7);
    chk("rst_int", {31'd0, INT}, 32'd0);
    RESET = 1'b0;

    run_req("wr64", 1'b1, 8'h64, 8'hA5, 1'b0, 8'h00, 0, -1, 40, 0, 1'b0);
    run_req("rd60", 1'b0, 8'h60, 8'h00, 1'b1, 8'h3C, 0, -1, 40, 0, 1'b0);
    run_req("rd_open", 1'b0, 8'h70, 8'h00, 1'b0, 8'h00, 0, -1, 40, 0, 1'b0);
    run_req("wr_wait", 1'b1, 8'h98, 8'h11, 1'b0, 8'h00, 7, 24, 60, 2, 1'b0);
`ifdef MSX_IO_INITIATOR_TIMEOUT_EN
    run_req("rd_tmo", 1'b0, 8'h61, 8'h00, 1'b1, 8'h55, 7, 100000, 60, 3, 1'b1);
`else
    run_req("rd_hold", 1'b0, 8'h61, 8'h00, 1'b1, 8'h55, 7, 99, 150, 14, 1'b0);
`endif

    @(negedge CLK);
    BUS_INT_n = 1'b0;
    @(negedge CLK);
    chk("int_sync1", {31'd0, INT}, 32'd0);
    @(negedge CLK);
    chk("int_sync2", {31'd0, INT}, 32'd1);
    BUS_INT_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("int_release", {31'd0, INT}, 32'd0);

    @(negedge CLK);
    REQ      = 1'b1;
    REQ_WR   = 1'b0;
    REQ_ADDR = 8'h60;
    @(posedge CLK);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      REQ = 1'b0;
    end
    RESET = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'd0, BUS_IORQ_n, BUS_RD_n, BUS_WR_n}, 32'd7);
    chk("rst_mid_ready", {31'd0, READY}, 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("rst_mid_no_done", dones, 0);

    run_req("post_rst", 1'b1, 8'h12, 8'h5A, 1'b0, 8'h00, 0, -1, 40, 0, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
